// File: rtl/as2650_wb_mailbox.sv
// Wishbone classic mailbox between the Caravel management SoC and the AS2650 core.
// Optional macro AS2650_MBOX_H2C_IRQ_EN adds a CTRL bit that raises irq_o when the H2C FIFO runs empty.
module as2650_wb_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cpu_rst_n_o,
    output logic [7:0]  h2c_data_o,
    output logic        h2c_valid_o,
    input  logic        h2c_ready_i,
    input  logic [7:0]  c2h_data_i,
    input  logic        c2h_valid_i,
    output logic        c2h_ready_o,
    output logic        irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_H2C    = 2'd2,
        REG_C2H    = 2'd3
    } reg_e;

    logic cpu_hold, irq_en, ovf;
`ifdef AS2650_MBOX_H2C_IRQ_EN
    logic h2c_irq_en;
`endif

    logic [7:0]    h2c_mem [DEPTH];
    logic [AW-1:0] h2c_wr_ptr, h2c_rd_ptr;
    logic [CW-1:0] h2c_count;
    logic [7:0]    c2h_mem [DEPTH];
    logic [AW-1:0] c2h_wr_ptr, c2h_rd_ptr;
    logic [CW-1:0] c2h_count;

    logic  hit, req, wr_req, rd_req, ctrl_wr;
    reg_e  reg_sel;
    logic  h2c_full, h2c_empty, h2c_wr, h2c_push, h2c_pop, h2c_ovf;
    logic  c2h_full, c2h_empty, c2h_push, c2h_pop;
    logic  irq_next;
    logic [31:0] ctrl_value, status_value, rd_data;
    logic  unused_ok;

    assign hit     = wbs_adr_i[31:4] == BASE_ADDR[31:4];
    assign req     = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign reg_sel = reg_e'(wbs_adr_i[3:2]);
    assign wr_req  = req & wbs_we_i;
    assign rd_req  = req & ~wbs_we_i;
    assign ctrl_wr = wr_req & (reg_sel == REG_CTRL) & wbs_sel_i[0];

    assign h2c_full  = h2c_count == FULL_COUNT;
    assign h2c_empty = h2c_count == '0;
    assign c2h_full  = c2h_count == FULL_COUNT;
    assign c2h_empty = c2h_count == '0;

    // A host write into a full H2C FIFO is dropped and latched as an overflow.
    assign h2c_wr   = wr_req & (reg_sel == REG_H2C) & wbs_sel_i[0];
    assign h2c_push = h2c_wr & ~h2c_full;
    assign h2c_ovf  = h2c_wr & h2c_full;
    assign h2c_pop  = h2c_valid_o & h2c_ready_i;
    assign c2h_push = c2h_valid_i & c2h_ready_o;
    assign c2h_pop  = rd_req & (reg_sel == REG_C2H) & ~c2h_empty;

    assign h2c_valid_o = ~h2c_empty;
    assign h2c_data_o  = h2c_mem[h2c_rd_ptr];
    assign c2h_ready_o = ~c2h_full;

    assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    always_comb begin
        ctrl_value    = '0;
        ctrl_value[0] = cpu_hold;
        ctrl_value[1] = irq_en;
`ifdef AS2650_MBOX_H2C_IRQ_EN
        ctrl_value[3] = h2c_irq_en;
`endif
    end

    assign status_value = {8'h00, 8'(c2h_count), 8'(h2c_count), 3'b000,
                           ovf, c2h_empty, c2h_full, h2c_empty, h2c_full};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL:   rd_data = ctrl_value;
            REG_STATUS: rd_data = status_value;
            REG_H2C:    rd_data = '0;
            REG_C2H:    rd_data = c2h_empty ? 32'h0 : {23'b0, 1'b1, c2h_mem[c2h_rd_ptr]};
            default:    rd_data = '0;
        endcase
    end

`ifdef AS2650_MBOX_H2C_IRQ_EN
    assign irq_next = (irq_en & ~c2h_empty) | (h2c_irq_en & h2c_empty);
`else
    assign irq_next = irq_en & ~c2h_empty;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            cpu_hold    <= 1'b1;
            irq_en      <= 1'b0;
            ovf         <= 1'b0;
            cpu_rst_n_o <= 1'b0;
            irq_o       <= 1'b0;
`ifdef AS2650_MBOX_H2C_IRQ_EN
            h2c_irq_en  <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= req;
            if (req) wbs_dat_o <= wbs_we_i ? 32'h0 : rd_data;
            if (ctrl_wr) begin
                cpu_hold   <= wbs_dat_i[0];
                irq_en     <= wbs_dat_i[1];
`ifdef AS2650_MBOX_H2C_IRQ_EN
                h2c_irq_en <= wbs_dat_i[3];
`endif
            end
            if (h2c_ovf) ovf <= 1'b1;
            else if (ctrl_wr & wbs_dat_i[2]) ovf <= 1'b0;
            cpu_rst_n_o <= ~cpu_hold;
            irq_o       <= irq_next;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (h2c_push) h2c_mem[h2c_wr_ptr] <= wbs_dat_i[7:0];
        if (c2h_push) c2h_mem[c2h_wr_ptr] <= c2h_data_i;
    end

    // Pointers wrap naturally at DEPTH; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            h2c_wr_ptr <= '0;
            h2c_rd_ptr <= '0;
            h2c_count  <= '0;
            c2h_wr_ptr <= '0;
            c2h_rd_ptr <= '0;
            c2h_count  <= '0;
        end else begin
            if (h2c_push) h2c_wr_ptr <= h2c_wr_ptr + AW'(1);
            if (h2c_pop)  h2c_rd_ptr <= h2c_rd_ptr + AW'(1);
            case ({h2c_push, h2c_pop})
                2'b10:   h2c_count <= h2c_count + CW'(1);
                2'b01:   h2c_count <= h2c_count - CW'(1);
                default: h2c_count <= h2c_count;
            endcase
            if (c2h_push) c2h_wr_ptr <= c2h_wr_ptr + AW'(1);
            if (c2h_pop)  c2h_rd_ptr <= c2h_rd_ptr + AW'(1);
            case ({c2h_push, c2h_pop})
                2'b10:   c2h_count <= c2h_count + CW'(1);
                2'b01:   c2h_count <= c2h_count - CW'(1);
                default: c2h_count <= c2h_count;
            endcase
        end
    end

endmodule

// File: tb/tb_as2650_wb_mailbox.sv
// Scoreboard testbench for as2650_wb_mailbox: bus reads queue expected data, a monitor checks every ack.
`timescale 1ns/1ps
module tb_as2650_wb_mailbox;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cpu_rst_n_o;
    logic [7:0]  h2c_data_o;
    logic        h2c_valid_o;
    logic        h2c_ready_i = 1'b0;
    logic [7:0]  c2h_data_i = 8'h00;
    logic        c2h_valid_i = 1'b0;
    logic        c2h_ready_o;
    logic        irq_o;

    logic [31:0] exp_data [$];
    logic        exp_chk  [$];
    string       exp_name [$];
    int          checks = 0;
    int          errors = 0;

    as2650_wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .cpu_rst_n_o(cpu_rst_n_o),
        .h2c_data_o(h2c_data_o), .h2c_valid_o(h2c_valid_o), .h2c_ready_i(h2c_ready_i),
        .c2h_data_i(c2h_data_i), .c2h_valid_i(c2h_valid_i), .c2h_ready_o(c2h_ready_o),
        .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // One Wishbone transaction; the expected read data goes to the scoreboard before the request.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] dat, input logic chk,
                                 input logic [31:0] expected, input string name);
        logic got;
        exp_data.push_back(expected);
        exp_chk.push_back(chk);
        exp_name.push_back(name);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_ack: got no ack, expected ack within 16 cycles", name);
            void'(exp_data.pop_back());
            void'(exp_chk.pop_back());
            void'(exp_name.pop_back());
        end
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] expected, input string name);
        applyStimulus(1'b0, adr, 4'hF, 32'h0, 1'b1, expected, name);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string name);
        applyStimulus(1'b1, adr, 4'hF, dat, 1'b0, 32'h0, name);
    endtask

    task automatic monitor();
        logic [31:0] d;
        logic        c;
        string       n;
        forever begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ack: got ack with data 0x%08h, expected no ack", wbs_dat_o);
                end else begin
                    d = exp_data.pop_front();
                    c = exp_chk.pop_front();
                    n = exp_name.pop_front();
                    if (c) begin
                        checks++;
                        if (wbs_dat_o !== d) begin
                            errors++;
                            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", n, wbs_dat_o, d);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int acks;
        fork
            monitor();
        join_none

        repeat (3) @(posedge wb_clk_i);
        #1;
        checkOutput("reset_ack", 32'(wbs_ack_o), 0);
        checkOutput("reset_dat", wbs_dat_o, 0);
        checkOutput("reset_cpu_rst_n", 32'(cpu_rst_n_o), 0);
        checkOutput("reset_h2c_valid", 32'(h2c_valid_o), 0);
        checkOutput("reset_c2h_ready", 32'(c2h_ready_o), 1);
        checkOutput("reset_irq", 32'(irq_o), 0);
        wb_rst_n = 1'b1;
        tick();

        $display("[TB] reset values and release of CPU hold");
        rd(BASE + 32'h0, 32'h0000_0001, "ctrl_reset");
        rd(BASE + 32'h4, 32'h0000_000A, "status_reset");
        wr(BASE + 32'h0, 32'h0, "ctrl_release");
        checkOutput("cpu_rst_n_at_ack", 32'(cpu_rst_n_o), 0);
        tick();
        checkOutput("cpu_rst_n_after_ack", 32'(cpu_rst_n_o), 1);
        checkOutput("ack_one_cycle", 32'(wbs_ack_o), 0);

        $display("[TB] access outside the window");
        acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = BASE + 32'h10; wbs_dat_i = 32'h0000_0001;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        checkOutput("outside_no_ack", 32'(acks), 0);
        checkOutput("outside_no_side_effect", 32'(cpu_rst_n_o), 1);

        $display("[TB] H2C show-ahead and core pop");
        applyStimulus(1'b1, BASE + 32'h8, 4'b1110, 32'hEE, 1'b0, 32'h0, "h2c_nosel");
        checkOutput("h2c_nosel_empty", 32'(h2c_valid_o), 0);
        wr(BASE + 32'h8, 32'hA5, "h2c_a5");
        wr(BASE + 32'h8, 32'h3C, "h2c_3c");
        checkOutput("h2c_head_a5", 32'(h2c_data_o), 32'hA5);
        checkOutput("h2c_valid", 32'(h2c_valid_o), 1);
        rd(BASE + 32'h4, 32'h0000_0208, "status_h2c2");
        rd(BASE + 32'h8, 32'h0, "h2c_read_zero");
        h2c_ready_i = 1'b1;
        tick();
        h2c_ready_i = 1'b0;
        checkOutput("h2c_head_3c", 32'(h2c_data_o), 32'h3C);
        h2c_ready_i = 1'b1;
        tick();
        h2c_ready_i = 1'b0;
        checkOutput("h2c_drained", 32'(h2c_valid_o), 0);

        $display("[TB] H2C overflow");
        for (int i = 0; i < 9; i++) wr(BASE + 32'h8, 32'h10 + 32'(i), "h2c_fill");
        rd(BASE + 32'h4, 32'h0000_0819, "status_full_ovf");
        checkOutput("h2c_head_after_fill", 32'(h2c_data_o), 32'h10);
        wr(BASE + 32'h0, 32'h4, "ctrl_clear_ovf");
        rd(BASE + 32'h4, 32'h0000_0809, "status_ovf_cleared");
        rd(BASE + 32'h0, 32'h0, "ctrl_ovf_bit_reads_zero");
        h2c_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("h2c_drain_order", 32'(h2c_data_o), 32'h10 + 32'(i));
            tick();
        end
        h2c_ready_i = 1'b0;
        checkOutput("h2c_empty_after_drain", 32'(h2c_valid_o), 0);

        $display("[TB] C2H push, irq and host pop");
        wr(BASE + 32'h0, 32'h2, "ctrl_irq_en");
        c2h_valid_i = 1'b1; c2h_data_i = 8'h11;
        tick();
        c2h_data_i = 8'h22;
        tick();
        c2h_valid_i = 1'b0;
        tick();
        checkOutput("irq_c2h_data", 32'(irq_o), 1);
        rd(BASE + 32'h4, 32'h0002_0002, "status_c2h2");
        wr(BASE + 32'hC, 32'hFF, "c2h_write_ignored");
        rd(BASE + 32'hC, 32'h0000_0111, "c2h_pop_11");
        rd(BASE + 32'hC, 32'h0000_0122, "c2h_pop_22");
        tick();
        checkOutput("irq_c2h_empty", 32'(irq_o), 0);
        rd(BASE + 32'hC, 32'h0, "c2h_pop_empty");

        $display("[TB] reset in mid-transaction");
        wr(BASE + 32'h8, 32'h77, "h2c_77");
        wr(BASE + 32'h8, 32'h88, "h2c_88");
        c2h_valid_i = 1'b1; c2h_data_i = 8'h99;
        tick();
        c2h_valid_i = 1'b0;
        tick();
        tick();
        checkOutput("irq_before_reset", 32'(irq_o), 1);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h4;
        tick();
        checkOutput("ack_before_reset", 32'(wbs_ack_o), 1);
        #1 wb_rst_n = 1'b0;
        #1;
        checkOutput("reset_drops_ack", 32'(wbs_ack_o), 0);
        checkOutput("reset_cpu_held", 32'(cpu_rst_n_o), 0);
        checkOutput("reset_h2c_flushed", 32'(h2c_valid_o), 0);
        checkOutput("reset_c2h_ready", 32'(c2h_ready_o), 1);
        checkOutput("reset_irq_low", 32'(irq_o), 0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        wb_rst_n = 1'b1;
        tick();
        rd(BASE + 32'h4, 32'h0000_000A, "status_after_reset");
        rd(BASE + 32'h0, 32'h0000_0001, "ctrl_after_reset");

        tick();
        tick();
        checkOutput("scoreboard_drained", 32'(exp_data.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
